serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
// PURPOSE
//  Multi-cycle ripple-borrow subtractor computing diff = a - b - b_in.
//  Processes DIGIT bits per clock, LSB digit first. The borrow chain is carried in a
//  register between cycles, trading latency for area against the combinational carry chain.
//  Sits beside the combinational adders in the datapath; uses a valid/ready handshake on
//  both the operand side and the result side.
// PARAMETERS
//  N      8  operand/result width in bits
//  DIGIT  1  bits processed per cycle; must divide N exactly (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a, b, b_in are valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   N      minuend
//  b          in   N      subtrahend
//  b_in       in   1      borrow in
//  out_valid  out  1      diff/b_out are valid
//  out_ready  in   1      consumer accepts the result
//  diff       out  N      a - b - b_in, modulo 2^N
//  b_out      out  1      final borrow: 1 iff a < b + b_in (unsigned)
// BEHAVIOUR
//  Reset (rst_n low, any time, asynchronous):
//   - state = IDLE; in_ready = 1 once released; out_valid = 0; diff = 0; b_out = 0;
//     digit counter = 0; borrow register = 0.
//   - Reset mid-RUN or mid-DONE abandons the operation; no partial result is emitted.
//  FSM:
//   - IDLE -> RUN on in_valid && in_ready at a clock edge. That edge latches a, b into
//     shift registers, loads b_in into the borrow register, and sets count = 0.
//   - RUN, each edge, for bits j of the current digit (i = count*DIGIT + j), borrow
//     rippling through j within the cycle:
//       d_i    = a_i ^ b_i ^ bw_i
//       bw_i+1 = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i)
//     The result digit shifts into diff from the MSB side; count increments.
//   - RUN -> DONE on the edge that processes digit N/DIGIT-1. The same edge sets
//     out_valid = 1 and b_out = the final borrow.
//   - DONE -> IDLE on out_valid && out_ready. out_valid drops after that edge;
//     in_ready rises.
//  Timing:
//   - Latency: out_valid is high starting N/DIGIT cycles after the accept edge.
//   - Throughput: one operation per N/DIGIT + 2 cycles at best.
//   - No overlap: in_ready = 0 in RUN and DONE, so in_valid is ignored there.
//  Result hold:
//   - diff/b_out stay stable while out_valid && !out_ready; no limit on stall length.
//   - diff/b_out keep the last result after the handshake, until the next completion.
//   - Operand inputs may change freely after the accept edge.
//  Arithmetic boundaries:
//   - Wrap-around is modulo 2^N.
//   - b_in = 1 with a = b gives diff = all ones, b_out = 1.
//   - b = 0, b_in = 0 gives diff = a, b_out = 0.
// CONFIGURATION
//  SUB_OVERFLOW_EN defined:
//   - Adds output port ovf (1 bit). It is the signed two's-complement overflow of a - b - b_in.
//   - ovf = borrow into MSB XOR borrow out of MSB.
//   - Captured on the same edge as b_out; same reset (0) and hold rules as b_out.
//  SUB_OVERFLOW_EN undefined:
//   - Port ovf does not exist; no overflow logic is built.
// TESTING (N=8, DIGIT=1 unless stated)
//  1. a=0x05 b=0x03 b_in=0 -> diff=0x02, b_out=0; out_valid exactly 8 cycles after accept.
//  2. a=0x03 b=0x05 b_in=0 -> diff=0xFE, b_out=1.
//     Then a=0x00 b=0x00 b_in=1 -> diff=0xFF, b_out=1.
//  3. Hold out_ready=0 for 5 cycles in DONE:
//     -> out_valid, diff, b_out stable; in_ready=0; a new in_valid pulse is ignored.
//  4. Assert rst_n=0 at RUN count=3 -> out_valid=0, diff=0 immediately.
//     After release, a=0x10 b=0x01 -> diff=0x0F.
//  5. DIGIT=4: a=0xA7 b=0x58 b_in=0 -> diff=0x4F, b_out=0; latency 2 cycles.
//  6. SUB_OVERFLOW_EN: a=0x80 b=0x01 -> diff=0x7F, ovf=1.
//     a=0x7F b=0x01 -> diff=0x7E, ovf=0.
//  Throughout: random back-to-back operands checked against a - b - b_in; no accept
//  while in_ready=0.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_ripple_subtractor                                     |
// | Description : Multi-cycle ripple-borrow subtractor, diff = a - b - b_in.   |
// |               Processes DIGIT bits per clock, LSB digit first. The borrow  |
// |               is held in a register between digits. Operands and results   |
// |               each use a valid/ready handshake.                            |
// | Parameters  : N      operand/result width                                  |
// |               DIGIT  bits per cycle, must divide N exactly                 |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               in_valid/in_ready, a, b, b_in   operand side                 |
// |               out_valid/out_ready, diff, b_out result side                 |
// |               ovf   signed overflow (only with SUB_OVERFLOW_EN)            |
// | Options     : `define SUB_OVERFLOW_EN adds the ovf output and its logic    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module serial_ripple_subtractor #(
  parameter int N     = 8,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         b_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int c_NUM_DIGITS = N / DIGIT;
  localparam int c_CNT_W      = (c_NUM_DIGITS > 1) ? $clog2(c_NUM_DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_NUM_DIGITS - 1);

  generate
    if ((DIGIT < 1) || ((N % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_ripple_subtractor: DIGIT must divide N exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;
  logic                w_run;
  logic                w_last;

  logic [N-1:0]        r_a;
  logic [N-1:0]        r_b;
  logic                r_borrow;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [N-1:0]        r_diff;
  logic                r_bout;

  logic [DIGIT-1:0]    w_digit;
  logic                w_bw_out;
  logic [N-1:0]        w_acc_next;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (r_cnt == c_LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------- per-digit borrow ripple
`ifdef SUB_OVERFLOW_EN
  logic w_bw_msb_in;  // borrow entering the top bit of the current digit
`endif

  always_comb begin
    logic v_bw;
    v_bw     = r_borrow;
    w_digit  = '0;
`ifdef SUB_OVERFLOW_EN
    w_bw_msb_in = 1'b0;
`endif
    for (int j = 0; j < DIGIT; j++) begin
`ifdef SUB_OVERFLOW_EN
      if (j == DIGIT - 1) begin
        w_bw_msb_in = v_bw;
      end
`endif
      w_digit[j] = r_a[j] ^ r_b[j] ^ v_bw;
      v_bw       = (~r_a[j] & r_b[j]) | (~(r_a[j] ^ r_b[j]) & v_bw);
    end
    w_bw_out = v_bw;
  end

  // Result digits enter from the MSB side. The working accumulator keeps only
  // the N-DIGIT bits that still have to shift down; the final digit completes
  // the word straight into the output register, so diff is only updated on
  // completion and otherwise holds the previous result.
  generate
    if (DIGIT == N) begin : g_full_digit
      assign w_acc_next = w_digit;
    end else begin : g_partial_digit
      logic [N-DIGIT-1:0] r_acc;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_run) begin
          r_acc <= w_acc_next[N-1:DIGIT];
        end
      end

      assign w_acc_next = {w_digit, r_acc};
    end
  endgenerate

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= b_in;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_bw_out;
      r_cnt    <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        r_diff <= w_acc_next;
        r_bout <= w_bw_out;
      end
    end
  end

  assign diff  = r_diff;
  assign b_out = r_bout;

`ifdef SUB_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow: the borrow into the MSB disagrees with the borrow out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_run && w_last) begin
      r_ovf <= w_bw_msb_in ^ w_bw_out;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_ripple_subtractor                                  |
// | Description : Self-checking bench for serial_ripple_subtractor. Directed   |
// |               vector table, stall/reset sequences, DIGIT=4 instance and    |
// |               randomized operands against an arithmetic reference model.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_serial_ripple_subtractor;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       bin_s;
  logic       iv1, iv4, or1, or4;
  logic       ir1, ir4, ov1, ov4, bo1, bo4;
  logic [7:0] d1, d4;
`ifdef SUB_OVERFLOW_EN
  logic       ovf1, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  serial_ripple_subtractor #(.N(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a_s), .b(b_s), .b_in(bin_s), .out_valid(ov1), .out_ready(or1),
    .diff(d1), .b_out(bo1)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  serial_ripple_subtractor #(.N(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a_s), .b(b_s), .b_in(bin_s), .out_valid(ov4), .out_ready(or4),
    .diff(d4), .b_out(bo4)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  // Reference: plain integer arithmetic, unsigned for diff/borrow, signed for ovf.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic bi);
    int ud;
    int sd;
    logic [7:0] d;
    logic bo;
    logic ov;
    ud = int'(x) - int'(y) - int'(bi);
    sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
    d  = ud[7:0];
    bo = (ud < 0);
    ov = (sd > 127) || (sd < -128);
    return {ov, bo, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic f_ir(input bit sel);
    return sel ? ir4 : ir1;
  endfunction
  function automatic logic f_ov(input bit sel);
    return sel ? ov4 : ov1;
  endfunction
  function automatic logic [7:0] f_d(input bit sel);
    return sel ? d4 : d1;
  endfunction
  function automatic logic f_bo(input bit sel);
    return sel ? bo4 : bo1;
  endfunction
`ifdef SUB_OVERFLOW_EN
  function automatic logic f_ovf(input bit sel);
    return sel ? ovf4 : ovf1;
  endfunction
`endif

  task automatic set_iv(input bit sel, input logic v);
    if (sel) iv4 = v; else iv1 = v;
  endtask
  task automatic set_or(input bit sel, input logic v);
    if (sel) or4 = v; else or1 = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency, result, optional stall, handshake.
  task automatic run_op(input bit sel, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input int stall,
                        input logic [7:0] ediff, input logic ebout, input logic eovf,
                        input int elat, input string tag);
    int lat;
    logic [7:0] dprev;
    lat = 0;
    while (!f_ir(sel) && lat < 100) begin
      step();
      lat++;
    end
    if (!f_ir(sel)) begin
      chk({tag, "_ready_timeout"}, 32'(f_ir(sel)), 32'd1);
      return;
    end
    dprev = f_d(sel);
    a_s = ta; b_s = tb; bin_s = tbin;
    set_iv(sel, 1'b1);
    step();                               // accept edge
    set_iv(sel, 1'b0);
    a_s = 8'($urandom); b_s = 8'($urandom); bin_s = 1'($urandom);
    chk({tag, "_in_ready_busy"}, 32'(f_ir(sel)), 32'd0);
    lat = 0;
    while (!f_ov(sel) && lat < 100) begin
      chk({tag, "_diff_hold_run"}, 32'(f_d(sel)), 32'(dprev));
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    if (!f_ov(sel)) return;
    chk({tag, "_diff"}, 32'(f_d(sel)), 32'(ediff));
    chk({tag, "_b_out"}, 32'(f_bo(sel)), 32'(ebout));
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, 32'(f_ovf(sel)), 32'(eovf));
`endif
    set_or(sel, 1'b0);
    for (int k = 0; k < stall; k++) begin
      if (k == 0) begin
        a_s = ~ta; b_s = ta; bin_s = ~tbin;
        set_iv(sel, 1'b1);              // must be ignored while busy
      end
      step();
      set_iv(sel, 1'b0);
      chk({tag, "_stall_valid"}, 32'(f_ov(sel)), 32'd1);
      chk({tag, "_stall_ready"}, 32'(f_ir(sel)), 32'd0);
      chk({tag, "_stall_diff"}, 32'(f_d(sel)), 32'(ediff));
      chk({tag, "_stall_bout"}, 32'(f_bo(sel)), 32'(ebout));
    end
    set_or(sel, 1'b1);
    step();
    set_or(sel, 1'b0);
    chk({tag, "_post_valid"}, 32'(f_ov(sel)), 32'd0);
    chk({tag, "_post_ready"}, 32'(f_ir(sel)), 32'd1);
    chk({tag, "_post_diff"}, 32'(f_d(sel)), 32'(ediff));
    chk({tag, "_post_bout"}, 32'(f_bo(sel)), 32'(ebout));
  endtask

  initial begin
    logic [9:0] m;
    logic [7:0] x, y;
    logic       bi;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[6] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0; or1 = 1'b0; or4 = 1'b0;
    a_s = '0; b_s = '0; bin_s = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_in_ready", 32'(ir1), 32'd1);
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_diff", 32'(d1), 32'd0);
    chk("rst_b_out", 32'(bo1), 32'd0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", 32'(ovf1), 32'd0);
`endif

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, 0,
             vecs[i].diff, vecs[i].bout, vecs[i].ovf, 8, $sformatf("vec%0d", i));
    end

    // Long stall in DONE with an in_valid pulse that must be ignored
    run_op(1'b0, 8'h3C, 8'h0F, 1'b0, 5, 8'h2D, 1'b0, 1'b0, 8, "stall5");
    repeat (3) begin
      step();
      chk("stall5_no_restart", 32'(ov1), 32'd0);
    end

    // Asynchronous reset in RUN at count=3
    a_s = 8'h33; b_s = 8'h11; bin_s = 1'b0;
    iv1 = 1'b1;
    step();
    iv1 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 32'(ov1), 32'd0);
    chk("midrun_rst_diff", 32'(d1), 32'd0);
    chk("midrun_rst_b_out", 32'(bo1), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrun_rst_in_ready", 32'(ir1), 32'd1);
    repeat (10) begin
      step();
      chk("midrun_rst_no_result", 32'(ov1), 32'd0);
    end
    run_op(1'b0, 8'h10, 8'h01, 1'b0, 0, 8'h0F, 1'b0, 1'b0, 8, "rst_recover");

    // DIGIT=4 instance
    run_op(1'b1, 8'hA7, 8'h58, 1'b0, 0, 8'h4F, 1'b0, 1'b0, 2, "d4_a7_58");
    run_op(1'b1, 8'h00, 8'h00, 1'b1, 2, 8'hFF, 1'b1, 1'b0, 2, "d4_zero_bin");
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
      m = model(x, y, bi);
      run_op(1'b1, x, y, bi, int'($urandom_range(0, 2)), m[7:0], m[8], m[9], 2, "d4_rand");
    end

    // Randomized back-to-back operations on the DIGIT=1 instance
    for (int i = 0; i < 150; i++) begin
      x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
      if (i % 10 == 0) y = x;
      if (i % 13 == 0) begin y = 8'h00; bi = 1'b0; end
      m = model(x, y, bi);
      run_op(1'b0, x, y, bi, int'($urandom_range(0, 2)), m[7:0], m[8], m[9], 8, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
